// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide controller for the MIPS ALU: radix-2 shift-add multiply and
// restoring divide over WIDTH cycles, owning the HI/LO registers.
module mdu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic             is_div, sign_a, sign_b, div_zero;
  logic [WIDTH-1:0] opnd_b;
  logic [WIDTH-1:0] hi_acc, lo_acc;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic [WIDTH:0]   mul_sum, shifted, diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quot, rem;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic take);
    return (take && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v,
                                                    input logic neg);
    return neg ? -v : v;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == FIX);
      if (state == IDLE && start) count <= '0;
      else if (state == CALC)     count <= count + CW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (count == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration: multiply shifts the product right, divide shifts the remainder left.
  always_comb begin
    mul_sum = {1'b0, hi_acc} + {1'b0, (lo_acc[0] ? opnd_b : '0)};
    shifted = {hi_acc, lo_acc[WIDTH-1]};
    diff    = shifted - {1'b0, opnd_b};
    if (is_div) begin
      hi_nxt = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      lo_nxt = {lo_acc[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      hi_nxt = mul_sum[WIDTH:1];
      lo_nxt = {mul_sum[0], lo_acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      is_div   <= op[1];
      sign_a   <= ~op[0] & A[WIDTH-1];
      sign_b   <= ~op[0] & B[WIDTH-1];
      div_zero <= op[1] && (B == '0);
      opnd_b   <= magnitude(B, ~op[0]);
      hi_acc   <= '0;
      lo_acc   <= magnitude(A, ~op[0]);
    end else if (state == CALC) begin
      hi_acc   <= hi_nxt;
      lo_acc   <= lo_nxt;
    end
  end

  // Remainder takes the dividend sign, so a zero divisor hands back A itself in HI.
  always_comb begin
    prod = cond_neg_2w({hi_acc, lo_acc}, sign_a ^ sign_b);
    quot = div_zero ? '1 : cond_neg_w(lo_acc, sign_a ^ sign_b);
    rem  = cond_neg_w(hi_acc, sign_a);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      HI <= '0;
      LO <= '0;
    end else if (state == FIX) begin
      if (is_div) begin
        HI <= rem;
        LO <= quot;
      end else begin
        {HI, LO} <= prod;
      end
    end else if (state == IDLE && !start) begin
      if (hi_we) HI <= wdata;
      if (lo_we) LO <= wdata;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: vector table plus hand sequences, results checked through a
// scoreboard queue popped on every done pulse.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A, B, wdata;
  logic        hi_we, lo_we;
  logic        busy, done;
  logic [31:0] HI, LO;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int n_ops    = 0;
  logic [63:0] sbq[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[13];

  mdu_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sbv, q, r;
    logic [63:0] p;
    sa  = $signed(a);
    sbv = $signed(b);
    case (o)
      2'b00: p = sa * sbv;
      2'b01: p = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sbv;
          r = sa % sbv;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else        p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  initial begin
    logic [63:0] exp;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got HI=%0h LO=%0h with no operation pending", HI, LO);
        end else begin
          exp = sbq.pop_front();
          check("result", {HI, LO}, exp);
        end
      end
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input bit with_we, input bit inject,
                        input bit we_in_done);
    int waited;
    bit ok;
    logic [31:0] hi_before, lo_before;
    waited = 0;
    while (busy && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    check("idle_before_start", busy, 1'b0);
    hi_before = HI;
    lo_before = LO;
    start = 1'b1; op = o; A = a; B = b;
    if (with_we) begin
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    end
    sbq.push_back(exp);
    n_ops++;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    A = $urandom; B = $urandom;
    check("busy_after_start", busy, 1'b1);
    if (with_we) check("start_beats_we", {HI, LO}, {hi_before, lo_before});
    ok = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      if (inject && k == 5) begin
        start = 1'b1; op = 2'b01; A = 32'd9; B = 32'd9;
        lo_we = 1'b1; wdata = 32'h0000_BEEF;
      end
      @(posedge clk); #1;
      if (inject && k == 5) begin
        start = 1'b0; lo_we = 1'b0;
        check("lo_we_busy", LO, lo_before);
      end
      if (!busy || done) ok = 1'b0;
    end
    check("busy_window", ok, 1'b1);
    @(posedge clk); #1;
    check("done_latency", {busy, done}, 2'b01);
    if (we_in_done) begin
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_0066;
    end
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    check("done_one_cycle", {busy, done}, 2'b00);
    if (we_in_done) check("we_in_done", {HI, LO}, {32'h66, 32'h66});
  endtask

  initial begin
    int dc;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{2'b11, 32'h0000_000A, 32'h0000_0000, 32'h0000_000A, 32'hFFFF_FFFF};
    vecs[4]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{2'b01, 32'h0000_0007, 32'h0000_0006, 32'h0000_0000, 32'h0000_002A};
    vecs[6]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[7]  = '{2'b11, 32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_0005, 32'h1999_9999};
    vecs[8]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[9]  = '{2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[10] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[11] = '{2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    vecs[12] = '{2'b01, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

    reset = 1'b1; start = 1'b0; op = 2'b00; A = '0; B = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {busy, done, HI, LO}, '0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo}, 1'b0, 1'b0, 1'b0);

    hi_we = 1'b1; wdata = 32'h0000_1234;
    @(posedge clk); #1;
    hi_we = 1'b0;
    check("mthi", HI, 32'h0000_1234);
    lo_we = 1'b1; wdata = 32'h0000_5678;
    @(posedge clk); #1;
    lo_we = 1'b0;
    check("mtlo", {HI, LO}, {32'h0000_1234, 32'h0000_5678});

    run_op(2'b01, 32'd2, 32'd3, 64'd6, 1'b1, 1'b1, 1'b0);
    run_op(2'b01, 32'd7, 32'd6, 64'd42, 1'b0, 1'b0, 1'b1);

    start = 1'b1; op = 2'b10; A = 32'd100; B = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("busy_before_reset", busy, 1'b1);
    dc = done_cnt;
    reset = 1'b1;
    #1;
    check("reset_abort", {busy, done, HI, LO}, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("no_done_after_reset", done_cnt, dc);
    check("idle_after_reset", {busy, HI, LO}, '0);
    run_op(2'b01, 32'd7, 32'd6, 64'd42, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 0) rb = 32'd0;
      if (i % 5 == 1) rb = $urandom_range(1, 15);
      run_op(ro, ra, rb, model(ro, ra, rb), 1'b0, 1'b0, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sbq.size(), 0);
    check("done_count", done_cnt, n_ops);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
